thread_rf: RTL and testbench
============================

Name: thread_rf

Overview:
Parametrised per-thread register file for an X-block, the next generation of the per-X-unit register file. It adds a configurable register count and data width, and three read ports sampled in the REQ state. It has two write channels: a pipeline writeback port and an independent LSU load-return port. A per-register load scoreboard with a stall output lets the compute unit issue a load without blocking until WRITEBACK. The top three registers are read-only identity registers: CU index, CU width and thread ID.

Parameters:
DATA_WIDTH, 16, register width in bits
NUM_REGS, 16, total registers; legal range 8..64
ADDR_WIDTH, 4, register address width; must equal clog2(NUM_REGS)
IMM_WIDTH, 8, decoded immediate width; must be less than DATA_WIDTH
CU_IDX, 0, reset value of register NUM_REGS-3
CU_WIDTH, 4, reset value of register NUM_REGS-2
THREAD_ID, 0, reset value of register NUM_REGS-1

Ports:
clk  in  1  clock; all state changes on its rising edge
reset  in  1  synchronous, active-high reset
rf_enable  in  1  gates all reads and all pipeline-side updates
cu_state  in  4  CU state: IDLE=0, FETCH=1, DECODE=2, REQ=3, WAIT=4, EXECUTE=5, WRITEBACK=6, DONE=7
cu_id_wen  in  1  scheduler load of the CU index register
cu_id  in  DATA_WIDTH  new CU index value
rs1_addr, rs2_addr, rs3_addr  in  ADDR_WIDTH each  read addresses
rd_addr  in  ADDR_WIDTH  destination address
rf_ren  in  1  read strobe, honoured only in REQ
rf_wen  in  1  writeback strobe, honoured only in WRITEBACK
wb_sel  in  2  writeback source: 0=none, 1=ALU, 2=sign-extended immediate, 3=load issue (no data)
imm  in  IMM_WIDTH  decoded immediate
alu_out_data  in  DATA_WIDTH  ALU result
lsu_wen  in  1  load-return write; accepted in any cu_state
lsu_waddr  in  ADDR_WIDTH  load-return destination
lsu_load_data  in  DATA_WIDTH  load-return data
rs1_data, rs2_data, rs3_data  out  DATA_WIDTH each  registered read data
stall  out  1  combinational; high when a requested source or the destination is pending
ro_write_err  out  1  sticky flag; set on any write attempt to a read-only register

Behaviour:
- Reset:
  - registers 0..NUM_REGS-4 = 0
  - NUM_REGS-3 = CU_IDX, NUM_REGS-2 = CU_WIDTH, NUM_REGS-1 = THREAD_ID
  - all pending bits = 0
  - rs1_data, rs2_data, rs3_data = 0; ro_write_err = 0
  - reset mid-load discards any outstanding pending state.
- Read-only region:
  - pipeline and LSU writes to addresses at or above NUM_REGS-3 are dropped and set ro_write_err.
  - cu_id_wen (requires rf_enable) is the only way to write register NUM_REGS-3.
  - addresses at or above NUM_REGS read as 0 and writes to them are dropped; no error flag.
- Read (REQ state, rf_enable and rf_ren): each rsN_data takes the register value at the next edge (1-cycle latency). Outputs hold their value otherwise.
- Write-through: if an LSU write hits the same address in the same cycle as a read, the read returns the LSU data. Pipeline writeback cannot coincide with REQ.
- Writeback (WRITEBACK state, rf_enable and rf_wen):
  - wb_sel=1: register[rd_addr] <= alu_out_data.
  - wb_sel=2: register[rd_addr] <= imm sign-extended to DATA_WIDTH.
  - wb_sel=3: no data write; pending[rd_addr] <= 1.
  - wb_sel=0: no effect.
- LSU return (lsu_wen): register[lsu_waddr] <= lsu_load_data and pending[lsu_waddr] <= 0. It is not gated by rf_enable or cu_state.
- Same-cycle collisions on the same address:
  - LSU write plus wb_sel 1 or 2: the pipeline value wins; pending is cleared.
  - LSU write plus wb_sel=3: data is written and pending ends set (the new load wins).
- stall = rf_enable AND (cu_state is DECODE or REQ) AND (any of pending[rs1_addr], pending[rs2_addr], pending[rs3_addr], pending[rd_addr] is set). It is combinational and reflects pending bits as of the current cycle; the CU holds its state while stall is high.
- Writes to address 0 are ordinary; there is no hardwired zero register.

Test Plan:
- Reset with NUM_REGS=16, THREAD_ID=5, CU_WIDTH=4, then REQ reads of addresses 15, 14, 3 -> rs1_data=5, rs2_data=4, rs3_data=0 one cycle after the REQ edge.
- WRITEBACK with wb_sel=2, imm=8'hF0, rd=2, then REQ read of 2 -> 16'hFFF0. Repeat with imm=8'h7F -> 16'h007F.
- WRITEBACK with wb_sel=3, rd=4, then DECODE with rs1=4 -> stall=1. Drive lsu_wen with waddr=4, data=16'h1234 -> stall=0 the next cycle and a REQ read of 4 returns 16'h1234.
- REQ read of rs2=6 in the same cycle as lsu_wen, waddr=6, data=16'hBEEF -> rs2_data=16'hBEEF (write-through).
- ALU writeback of 16'h0055 to rd=13 -> register 13 unchanged and ro_write_err=1, sticky until reset. cu_id_wen with cu_id=7 -> register 13 reads 7.
- Same-cycle LSU write (16'h1111) and ALU writeback (16'h2222) to address 9 -> register 9 reads 16'h2222 with pending clear. Repeat with NUM_REGS=32, DATA_WIDTH=32 -> THREAD_ID found at address 31.

Source files
------------

// File: rtl/thread_rf.sv
// thread_rf: per-thread register file for an X-block compute unit.
//
// Holds NUM_REGS registers of DATA_WIDTH bits. The top three are read-only
// identity registers (CU index, CU width, thread ID). Only the scheduler's
// cu_id_wen can rewrite the CU index register.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-high reset
//   rf_enable         gates reads, writeback and cu_id_wen (not LSU returns)
//   cu_state          CU state code (DECODE=2, REQ=3, WRITEBACK=6 used here)
//   cu_id_wen, cu_id  scheduler load of register NUM_REGS-3
//   rs1/2/3_addr      read addresses, sampled in REQ when rf_ren is high
//   rd_addr           writeback destination
//   rf_ren, rf_wen    read strobe (REQ only), writeback strobe (WRITEBACK only)
//   wb_sel, imm,      writeback source select: 1=ALU, 2=sign-extended imm,
//   alu_out_data      3=load issue (marks rd pending, writes no data)
//   lsu_wen/waddr/    load return: writes data and clears pending; accepted
//   lsu_load_data     in any state
//   rs1/2/3_data      registered read data, one cycle after the REQ edge
//   stall             combinational: a source or rd is waiting on a load
//   ro_write_err      sticky: a write targeted the read-only region
module thread_rf #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REGS   = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int IMM_WIDTH  = 8,
  parameter int CU_IDX     = 0,
  parameter int CU_WIDTH   = 4,
  parameter int THREAD_ID  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rf_enable,
  input  logic [3:0]            cu_state,
  input  logic                  cu_id_wen,
  input  logic [DATA_WIDTH-1:0] cu_id,
  input  logic [ADDR_WIDTH-1:0] rs1_addr,
  input  logic [ADDR_WIDTH-1:0] rs2_addr,
  input  logic [ADDR_WIDTH-1:0] rs3_addr,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic                  rf_ren,
  input  logic                  rf_wen,
  input  logic [1:0]            wb_sel,
  input  logic [IMM_WIDTH-1:0]  imm,
  input  logic [DATA_WIDTH-1:0] alu_out_data,
  input  logic                  lsu_wen,
  input  logic [ADDR_WIDTH-1:0] lsu_waddr,
  input  logic [DATA_WIDTH-1:0] lsu_load_data,
  output logic [DATA_WIDTH-1:0] rs1_data,
  output logic [DATA_WIDTH-1:0] rs2_data,
  output logic [DATA_WIDTH-1:0] rs3_data,
  output logic                  stall,
  output logic                  ro_write_err
);

  localparam logic [3:0] ST_DECODE = 4'd2;
  localparam logic [3:0] ST_REQ    = 4'd3;
  localparam logic [3:0] ST_WB     = 4'd6;

  // One extra bit so NUM_REGS itself is representable for range checks.
  localparam logic [ADDR_WIDTH:0] NREGS_X = (ADDR_WIDTH+1)'(NUM_REGS);
  localparam logic [ADDR_WIDTH:0] RO_BASE = (ADDR_WIDTH+1)'(NUM_REGS-3);

  localparam logic [DATA_WIDTH-1:0] CU_IDX_V    = DATA_WIDTH'(CU_IDX);
  localparam logic [DATA_WIDTH-1:0] CU_WIDTH_V  = DATA_WIDTH'(CU_WIDTH);
  localparam logic [DATA_WIDTH-1:0] THREAD_ID_V = DATA_WIDTH'(THREAD_ID);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [NUM_REGS-1:0]   pending;

  function automatic logic in_range(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < NREGS_X;
  endfunction

  function automatic logic is_ro(input logic [ADDR_WIDTH-1:0] a);
    return ({1'b0, a} >= RO_BASE) && in_range(a);
  endfunction

  function automatic logic is_pending(input logic [ADDR_WIDTH-1:0] a);
    return in_range(a) && pending[a];
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sext_imm(input logic [IMM_WIDTH-1:0] v);
    return {{(DATA_WIDTH-IMM_WIDTH){v[IMM_WIDTH-1]}}, v};
  endfunction

  logic lsu_ok, lsu_ro, wb_act, wb_ok, wb_ro, rd_fire;

  assign lsu_ok  = lsu_wen && in_range(lsu_waddr) && !is_ro(lsu_waddr);
  assign lsu_ro  = lsu_wen && is_ro(lsu_waddr);
  assign wb_act  = rf_enable && rf_wen && (cu_state == ST_WB) && (wb_sel != 2'd0);
  assign wb_ok   = wb_act && in_range(rd_addr) && !is_ro(rd_addr);
  assign wb_ro   = wb_act && is_ro(rd_addr);
  assign rd_fire = rf_enable && rf_ren && (cu_state == ST_REQ);

  // A same-cycle load return to the read address is forwarded so the read
  // sees the value that lands at this edge.
  function automatic logic [DATA_WIDTH-1:0] read_val(input logic [ADDR_WIDTH-1:0] a);
    if (lsu_ok && (lsu_waddr == a)) return lsu_load_data;
    if (in_range(a))                return regs[a];
    return '0;
  endfunction

  assign stall = rf_enable
              && ((cu_state == ST_DECODE) || (cu_state == ST_REQ))
              && (is_pending(rs1_addr) || is_pending(rs2_addr)
               || is_pending(rs3_addr) || is_pending(rd_addr));

  // Register array and scoreboard. The LSU update comes first so a
  // same-address pipeline write overrides it: ALU/imm data wins (pending
  // stays cleared by the LSU), a load issue re-arms pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (i == NUM_REGS-3)      regs[i] <= CU_IDX_V;
        else if (i == NUM_REGS-2) regs[i] <= CU_WIDTH_V;
        else if (i == NUM_REGS-1) regs[i] <= THREAD_ID_V;
        else                      regs[i] <= '0;
      end
      pending      <= '0;
      ro_write_err <= 1'b0;
    end else begin
      if (lsu_ok) begin
        regs[lsu_waddr]    <= lsu_load_data;
        pending[lsu_waddr] <= 1'b0;
      end
      if (wb_ok) begin
        case (wb_sel)
          2'd1:    regs[rd_addr]    <= alu_out_data;
          2'd2:    regs[rd_addr]    <= sext_imm(imm);
          2'd3:    pending[rd_addr] <= 1'b1;
          default: ;
        endcase
      end
      if (rf_enable && cu_id_wen) regs[NUM_REGS-3] <= cu_id;
      if (lsu_ro || wb_ro)        ro_write_err     <= 1'b1;
    end
  end

  // Read ports: one-cycle latency, hold when not fired.
  always_ff @(posedge clk) begin
    if (reset) begin
      rs1_data <= '0;
      rs2_data <= '0;
      rs3_data <= '0;
    end else if (rd_fire) begin
      rs1_data <= read_val(rs1_addr);
      rs2_data <= read_val(rs2_addr);
      rs3_data <= read_val(rs3_addr);
    end
  end

endmodule

// File: tb/tb_thread_rf.sv
// Testbench for thread_rf: two instances (16x16 with THREAD_ID=5, and
// 32x32 with THREAD_ID=9). Read expectations are queued at issue time and a
// negedge monitor pops and compares them when a read result is due.
module tb_thread_rf;

  localparam logic [3:0] S_IDLE = 4'd0, S_DECODE = 4'd2, S_REQ = 4'd3,
                         S_EXEC = 4'd5, S_WB = 4'd6;

  logic clk = 1'b0;
  logic reset;
  logic rf_enable;
  always #5 clk = ~clk;

  // Instance 1 signals (16 regs, 16 bits)
  logic [3:0]  cu_state;
  logic        cu_id_wen;
  logic [15:0] cu_id;
  logic [3:0]  rs1a, rs2a, rs3a, rda;
  logic        rf_ren, rf_wen;
  logic [1:0]  wb_sel;
  logic [7:0]  imm;
  logic [15:0] alu;
  logic        lsu_wen;
  logic [3:0]  lsu_waddr;
  logic [15:0] lsu_data;
  logic [15:0] r1, r2, r3;
  logic        stall, err;

  // Instance 2 signals (32 regs, 32 bits)
  logic [3:0]  st2;
  logic        cu_id_wen2;
  logic [31:0] cu_id2;
  logic [4:0]  rs1b, rs2b, rs3b, rdb;
  logic        ren2, wen2;
  logic [1:0]  sel2;
  logic [7:0]  imm2;
  logic [31:0] alu2;
  logic        lsu_wen2;
  logic [4:0]  lsu_waddr2;
  logic [31:0] lsu_data2;
  logic [31:0] q1o, q2o, q3o;
  logic        stall2, err2;

  thread_rf #(.DATA_WIDTH(16), .NUM_REGS(16), .ADDR_WIDTH(4), .IMM_WIDTH(8),
              .CU_IDX(0), .CU_WIDTH(4), .THREAD_ID(5)) dut (
    .clk(clk), .reset(reset), .rf_enable(rf_enable), .cu_state(cu_state),
    .cu_id_wen(cu_id_wen), .cu_id(cu_id),
    .rs1_addr(rs1a), .rs2_addr(rs2a), .rs3_addr(rs3a), .rd_addr(rda),
    .rf_ren(rf_ren), .rf_wen(rf_wen), .wb_sel(wb_sel), .imm(imm),
    .alu_out_data(alu), .lsu_wen(lsu_wen), .lsu_waddr(lsu_waddr),
    .lsu_load_data(lsu_data), .rs1_data(r1), .rs2_data(r2), .rs3_data(r3),
    .stall(stall), .ro_write_err(err));

  thread_rf #(.DATA_WIDTH(32), .NUM_REGS(32), .ADDR_WIDTH(5), .IMM_WIDTH(8),
              .CU_IDX(0), .CU_WIDTH(4), .THREAD_ID(9)) dut2 (
    .clk(clk), .reset(reset), .rf_enable(rf_enable), .cu_state(st2),
    .cu_id_wen(cu_id_wen2), .cu_id(cu_id2),
    .rs1_addr(rs1b), .rs2_addr(rs2b), .rs3_addr(rs3b), .rd_addr(rdb),
    .rf_ren(ren2), .rf_wen(wen2), .wb_sel(sel2), .imm(imm2),
    .alu_out_data(alu2), .lsu_wen(lsu_wen2), .lsu_waddr(lsu_waddr2),
    .lsu_load_data(lsu_data2), .rs1_data(q1o), .rs2_data(q2o), .rs3_data(q3o),
    .stall(stall2), .ro_write_err(err2));

  int n_chk  = 0;
  int n_pass = 0;

  logic [47:0] q1 [$];
  logic [95:0] q2 [$];
  logic vld1 = 1'b0, vld2 = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // A read result is due at the negedge following a fired REQ edge.
  always @(posedge clk) begin
    vld1 <= !reset && rf_enable && rf_ren && (cu_state == S_REQ);
    vld2 <= !reset && rf_enable && ren2 && (st2 == S_REQ);
  end

  always @(negedge clk) begin
    if (vld1) begin
      if (q1.size() == 0) chk("q1_underflow", 64'd1, 64'd0);
      else begin
        logic [47:0] e;
        e = q1.pop_front();
        chk("rs1_data", 64'(r1), 64'(e[47:32]));
        chk("rs2_data", 64'(r2), 64'(e[31:16]));
        chk("rs3_data", 64'(r3), 64'(e[15:0]));
      end
    end
    if (vld2) begin
      if (q2.size() == 0) chk("q2_underflow", 64'd1, 64'd0);
      else begin
        logic [95:0] e;
        e = q2.pop_front();
        chk("w32_rs1_data", 64'(q1o), 64'(e[95:64]));
        chk("w32_rs2_data", 64'(q2o), 64'(e[63:32]));
        chk("w32_rs3_data", 64'(q3o), 64'(e[31:0]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd3(input logic [3:0] a1, a2, a3, input logic [15:0] e1, e2, e3);
    cu_state = S_REQ; rf_ren = 1'b1;
    rs1a = a1; rs2a = a2; rs3a = a3;
    q1.push_back({e1, e2, e3});
    step();
    rf_ren = 1'b0; cu_state = S_IDLE;
  endtask

  task automatic wb(input logic [1:0] sel, input logic [3:0] rd, input logic [7:0] iv,
                    input logic [15:0] av);
    cu_state = S_WB; rf_wen = 1'b1; wb_sel = sel; rda = rd; imm = iv; alu = av;
    step();
    rf_wen = 1'b0; wb_sel = 2'd0; rda = 4'd0; cu_state = S_IDLE;
  endtask

  task automatic rd3b(input logic [4:0] a1, a2, a3, input logic [31:0] e1, e2, e3);
    st2 = S_REQ; ren2 = 1'b1;
    rs1b = a1; rs2b = a2; rs3b = a3;
    q2.push_back({e1, e2, e3});
    step();
    ren2 = 1'b0; st2 = S_IDLE;
  endtask

  initial begin
    reset = 1'b1; rf_enable = 1'b1;
    cu_state = S_IDLE; cu_id_wen = 1'b0; cu_id = '0;
    rs1a = '0; rs2a = '0; rs3a = '0; rda = '0;
    rf_ren = 1'b0; rf_wen = 1'b0; wb_sel = '0; imm = '0; alu = '0;
    lsu_wen = 1'b0; lsu_waddr = '0; lsu_data = '0;
    st2 = S_IDLE; cu_id_wen2 = 1'b0; cu_id2 = '0;
    rs1b = '0; rs2b = '0; rs3b = '0; rdb = '0;
    ren2 = 1'b0; wen2 = 1'b0; sel2 = '0; imm2 = '0; alu2 = '0;
    lsu_wen2 = 1'b0; lsu_waddr2 = '0; lsu_data2 = '0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state
    chk("rst_rs1", 64'(r1), 64'd0);
    chk("rst_rs2", 64'(r2), 64'd0);
    chk("rst_rs3", 64'(r3), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);

    // Identity registers
    rd3(4'd15, 4'd14, 4'd3, 16'd5, 16'd4, 16'd0);

    // Read with rf_enable low holds the outputs
    rf_enable = 1'b0; cu_state = S_REQ; rf_ren = 1'b1; rs1a = 4'd3;
    step();
    rf_enable = 1'b1; rf_ren = 1'b0; cu_state = S_IDLE;
    chk("hold_rs1", 64'(r1), 64'd5);

    // Sign-extended immediate writeback
    wb(2'd2, 4'd2, 8'hF0, 16'h0);
    rd3(4'd2, 4'd0, 4'd0, 16'hFFF0, 16'h0, 16'h0);
    wb(2'd2, 4'd2, 8'h7F, 16'h0);
    rd3(4'd2, 4'd0, 4'd0, 16'h007F, 16'h0, 16'h0);

    // Load issue marks reg 4 pending; stall only in DECODE/REQ
    wb(2'd3, 4'd4, 8'h0, 16'h0);
    cu_state = S_EXEC; rs1a = 4'd4; rs2a = 4'd0; rs3a = 4'd0; rda = 4'd0;
    #1 chk("stall_exec", 64'(stall), 64'd0);
    cu_state = S_DECODE;
    #1 chk("stall_decode", 64'(stall), 64'd1);
    rf_enable = 1'b0;
    #1 chk("stall_disabled", 64'(stall), 64'd0);
    rf_enable = 1'b1;
    lsu_wen = 1'b1; lsu_waddr = 4'd4; lsu_data = 16'h1234;
    step();
    lsu_wen = 1'b0;
    #1 chk("stall_cleared", 64'(stall), 64'd0);
    rd3(4'd4, 4'd0, 4'd0, 16'h1234, 16'h0, 16'h0);

    // Write-through of a same-cycle load return
    lsu_wen = 1'b1; lsu_waddr = 4'd6; lsu_data = 16'hBEEF;
    rd3(4'd0, 4'd6, 4'd0, 16'h0, 16'hBEEF, 16'h0);
    lsu_wen = 1'b0;
    rd3(4'd6, 4'd0, 4'd0, 16'hBEEF, 16'h0, 16'h0);

    // Read-only region and scheduler CU index load
    wb(2'd1, 4'd13, 8'h0, 16'h0055);
    chk("ro_err_set", 64'(err), 64'd1);
    rd3(4'd13, 4'd0, 4'd0, 16'h0000, 16'h0, 16'h0);
    cu_id_wen = 1'b1; cu_id = 16'd7;
    step();
    cu_id_wen = 1'b0;
    rd3(4'd13, 4'd14, 4'd15, 16'd7, 16'd4, 16'd5);
    chk("ro_err_sticky", 64'(err), 64'd1);

    // Collision: LSU + ALU writeback to 9, pipeline value wins
    lsu_wen = 1'b1; lsu_waddr = 4'd9; lsu_data = 16'h1111;
    wb(2'd1, 4'd9, 8'h0, 16'h2222);
    lsu_wen = 1'b0;
    cu_state = S_DECODE; rs1a = 4'd9; rs2a = 4'd0; rs3a = 4'd0; rda = 4'd0;
    #1 chk("coll_alu_stall", 64'(stall), 64'd0);
    rd3(4'd9, 4'd0, 4'd0, 16'h2222, 16'h0, 16'h0);

    // Collision: LSU + load issue to 10, data lands and pending ends set
    lsu_wen = 1'b1; lsu_waddr = 4'd10; lsu_data = 16'hAAAA;
    wb(2'd3, 4'd10, 8'h0, 16'h0);
    lsu_wen = 1'b0;
    cu_state = S_DECODE; rs1a = 4'd10; rs2a = 4'd0; rs3a = 4'd0; rda = 4'd0;
    #1 chk("coll_ld_stall", 64'(stall), 64'd1);
    rd3(4'd10, 4'd0, 4'd0, 16'hAAAA, 16'h0, 16'h0);

    // Reset while a load is outstanding
    wb(2'd3, 4'd11, 8'h0, 16'h0);
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    cu_state = S_DECODE; rs1a = 4'd11; rs2a = 4'd10; rs3a = 4'd0; rda = 4'd0;
    #1 chk("rst_pending_stall", 64'(stall), 64'd0);
    chk("rst_err_clear", 64'(err), 64'd0);
    rd3(4'd13, 4'd9, 4'd11, 16'h0, 16'h0, 16'h0);

    // Address 0 is ordinary; LSU write to read-only register flags an error
    wb(2'd1, 4'd0, 8'h0, 16'h00A5);
    chk("err_after_wb0", 64'(err), 64'd0);
    lsu_wen = 1'b1; lsu_waddr = 4'd14; lsu_data = 16'hFFFF;
    step();
    lsu_wen = 1'b0;
    chk("lsu_ro_err", 64'(err), 64'd1);
    rd3(4'd0, 4'd14, 4'd15, 16'h00A5, 16'h0004, 16'h0005);

    // 32-register, 32-bit instance
    rd3b(5'd31, 5'd30, 5'd29, 32'd9, 32'd4, 32'd0);
    st2 = S_WB; wen2 = 1'b1; sel2 = 2'd1; rdb = 5'd20; alu2 = 32'hDEADBEEF;
    step();
    sel2 = 2'd2; rdb = 5'd21; imm2 = 8'h80;
    step();
    wen2 = 1'b0; sel2 = 2'd0; st2 = S_IDLE;
    rd3b(5'd20, 5'd21, 5'd0, 32'hDEADBEEF, 32'hFFFFFF80, 32'd0);
    chk("w32_err", 64'(err2), 64'd0);

    repeat (3) step();
    chk("q1_drained", 64'(q1.size()), 64'd0);
    chk("q2_drained", 64'(q2.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
